fx_select_ctrl: RTL
===================

Name: fx_select_ctrl

Overview:
Sequencer that decides which effect core drives the codec outputs. It takes all effect-core outputs in parallel and a selector slider value. It switches effects click-free: fade the active core's samples to zero, swap the mux, then fade the new core in. It sits between the effect cores and codec_interface, and it only advances on codec VALID strobes.

Parameters:
NUM_FX, 4, number of effect cores; 2..8.
RAMP_LOG2, 6, fade length is 2^RAMP_LOG2 samples; also the gain fraction width.
SEL_STABLE, 4, number of consecutive VALID frames a new request must persist before it is accepted.

Ports:
clk  input  1  system clock.
RESET  input  1  asynchronous reset, active-high.
VALID  input  1  one-clk strobe per stereo frame from codec_interface.
sel_pot  input  12  selector slider, unsigned.
fx_left  input  16*NUM_FX  signed left samples; core k occupies bits [16k+15:16k].
fx_right  input  16*NUM_FX  signed right samples, same packing.
left_out  output  16  signed, gained left sample to codec.
right_out  output  16  signed, gained right sample to codec.
active_fx  output  $clog2(NUM_FX)  index currently routed to the outputs.
busy  output  1  high in any state other than RUN.

Behaviour:
- Reset (async, RESET=1): state=RUN, active_fx=0, gain=2^RAMP_LOG2, stable count=0, candidate=0, left_out=right_out=0, busy=0.
- Request decode: req = (sel_pot*NUM_FX)>>12, which is always in 0..NUM_FX-1.
- Qualification, evaluated on VALID only:
  - if req==candidate, count saturates upward at SEL_STABLE; otherwise candidate<=req and count<=1.
  - The accepted request is tgt = candidate once count==SEL_STABLE. Until then tgt holds its previous value (reset value 0).
- gain is unsigned, RAMP_LOG2+1 bits, range 0..2^RAMP_LOG2. The FSM advances only on a clk where VALID=1:
  - RUN: if tgt!=active_fx, go to FADE_OUT and decrement gain this same VALID.
  - FADE_OUT: gain-=1 per VALID. When gain reaches 0, go to SWAP. If tgt==active_fx again, go to FADE_IN without touching gain (reversal).
  - SWAP: active_fx<=tgt; gain stays 0; next state FADE_IN. Occupies exactly one VALID.
  - FADE_IN: gain+=1 per VALID. At gain==2^RAMP_LOG2 go to RUN. If tgt!=active_fx, go to FADE_OUT starting from the current gain.
- Datapath: on VALID, left_out<=(fx_left[active_fx]*$signed({1'b0,gain}))>>>RAMP_LOG2; right_out likewise.
  - Uses the active_fx and gain values present before this VALID's FSM update.
  - Product is 17+RAMP_LOG2+1 bits signed. Arithmetic shift, truncate toward −inf; no saturation needed.
  - Outputs hold between VALIDs. Latency is 1 clk after VALID.
- At full gain the output equals the input bit-exactly. At gain 0 the output is 0.
- A full switch takes 2^RAMP_LOG2 + 1 + 2^RAMP_LOG2 VALIDs after acceptance.
- busy is combinational from state.
- VALID asserted with RESET high is ignored. Reset mid-fade returns immediately to the reset values.

Optional Feature:
FXSEL_MUTE_EN
- Defined: adds input mute (1 bit) and state MUTED.
  - mute=1 in RUN or FADE_IN forces FADE_OUT. At gain 0 the FSM enters MUTED instead of SWAP; busy=1.
  - MUTED holds gain 0. When mute=0 it goes to SWAP if tgt!=active_fx, otherwise to FADE_IN.
  - mute takes priority over reversal.
- Undefined: no mute port, no MUTED state; behaviour exactly as above.

Test Plan:
- Reset: RESET=1 mid-run, sel_pot=0 -> left_out=right_out=0, active_fx=0, busy=0 asynchronously. Release, fx_left[0]=16'h1234 -> left_out=16'h1234 one clk after the next VALID.
- Pass-through: fx_left[0]=16'h8000, fx_right[0]=16'h7FFF, sel_pot steady 0 -> outputs exactly 8000/7FFF every VALID, busy=0.
- Switch: sel_pot=12'hC00 (req=3), fx_left[0]=16'sd6400 -> accepted after 4 VALIDs.
  - Then left_out steps 6300, 6200, ... to 0 over 64 VALIDs.
  - One SWAP frame with active_fx=3 and output 0.
  - fx_left[3] then ramps in over 64 VALIDs; busy=0 at end.
- Glitch rejection: sel_pot=12'h400 for 3 VALIDs, then back to 0 -> no state change, busy stays 0.
- Reversal: start a switch to 2, after 10 fade-out VALIDs return sel_pot to 0 (stable 4) -> FADE_IN from gain 50 back to 64, active_fx never changes.
- FXSEL_MUTE_EN: mute=1 in RUN -> gain reaches 0 after 64 VALIDs and stays 0 for 100 VALIDs. mute=0 -> fade in over 64 VALIDs with active_fx unchanged.

Source files
------------

// File: rtl/fx_select_ctrl_if.sv
// Bus between the effect cores / codec_interface and fx_select_ctrl.
// Optional mute input is present only when FXSEL_MUTE_EN is defined.
interface fx_select_ctrl_if #(
  parameter int NUM_FX = 4
);
  localparam int AW = $clog2(NUM_FX);

  logic                  VALID;
  logic [11:0]           sel_pot;
  logic [16*NUM_FX-1:0]  fx_left;
  logic [16*NUM_FX-1:0]  fx_right;
`ifdef FXSEL_MUTE_EN
  logic                  mute;
`endif
  logic [15:0]           left_out;
  logic [15:0]           right_out;
  logic [AW-1:0]         active_fx;
  logic                  busy;

  // Source side: codec strobe, slider and effect-core samples
  modport master (
    output VALID, sel_pot, fx_left, fx_right,
`ifdef FXSEL_MUTE_EN
    output mute,
`endif
    input  left_out, right_out, active_fx, busy
  );

  // Sequencer side
  modport slave (
    input  VALID, sel_pot, fx_left, fx_right,
`ifdef FXSEL_MUTE_EN
    input  mute,
`endif
    output left_out, right_out, active_fx, busy
  );
endinterface

// File: rtl/fx_select_ctrl.sv
// Click-free effect selector: qualifies the slider request, fades the active
// core out, swaps the mux, fades the new core in. Advances only on VALID.
// Optional feature macro: FXSEL_MUTE_EN (adds mute input and MUTED state).
module fx_select_ctrl #(
  parameter int NUM_FX     = 4,
  parameter int RAMP_LOG2  = 6,
  parameter int SEL_STABLE = 4
) (
  input  logic          clk,
  input  logic          RESET,
  fx_select_ctrl_if.slave bus
);
  localparam int AW = $clog2(NUM_FX);
  localparam int CW = $clog2(SEL_STABLE + 1);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = 16 + GW + 1;
  localparam logic [GW-1:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [CW-1:0] CNT_SAT   = CW'(SEL_STABLE);

  typedef enum logic [2:0] {
    ST_RUN, ST_FADE_OUT, ST_SWAP, ST_FADE_IN
`ifdef FXSEL_MUTE_EN
    , ST_MUTED
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gain_q, gain_d;
  logic [AW-1:0]   active_q, active_d;
  logic [AW-1:0]   cand_q, cand_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   tgt_q, tgt;
  logic [15:0]     left_q, left_d;
  logic [15:0]     right_q, right_d;

  logic [AW+11:0]  req_full;
  logic [AW-1:0]   req;
  logic            mute_req;
  logic            leave_full;

  logic signed [15:0]   fx_l_arr [NUM_FX];
  logic signed [15:0]   fx_r_arr [NUM_FX];
  logic signed [PW-1:0] prod_l, prod_r;
  logic                 unused_bits;

  // Slider decode: the top bits of sel_pot*NUM_FX pick the core
  assign req_full = (AW+12)'(bus.sel_pot) * (AW+12)'(NUM_FX);
  assign req      = req_full[AW+11:12];

`ifdef FXSEL_MUTE_EN
  assign mute_req = bus.mute;
`else
  assign mute_req = 1'b0;
`endif

  // Unpack the flat sample buses into per-core arrays
  generate
    for (genvar gi = 0; gi < NUM_FX; gi++) begin : g_unpack
      assign fx_l_arr[gi] = bus.fx_left[16*gi +: 16];
      assign fx_r_arr[gi] = bus.fx_right[16*gi +: 16];
    end
  endgenerate

  // Request qualification: a candidate must persist SEL_STABLE frames
  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    tgt     = (count_q == CNT_SAT) ? cand_q : tgt_q;
    if (bus.VALID) begin
      if (req == cand_q) begin
        if (count_q != CNT_SAT) count_d = count_q + CW'(1);
      end else begin
        cand_d  = req;
        count_d = CW'(1);
      end
    end
  end

  assign leave_full = (tgt != active_q) || mute_req;

  // Next-state and gain ramp; only a VALID frame moves the sequencer
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    active_d = active_q;
    if (bus.VALID) begin
      case (state_q)
        ST_RUN: begin
          if (leave_full) begin
            state_d = ST_FADE_OUT;
            gain_d  = gain_q - GW'(1);
          end
        end
        ST_FADE_OUT: begin
          if ((tgt == active_q) && !mute_req) begin
            state_d = ST_FADE_IN;
          end else if (gain_q <= GW'(1)) begin
            // also covers entry at gain 0 after an early reversal from FADE_IN
            gain_d = '0;
`ifdef FXSEL_MUTE_EN
            state_d = mute_req ? ST_MUTED : ST_SWAP;
`else
            state_d = ST_SWAP;
`endif
          end else begin
            gain_d = gain_q - GW'(1);
          end
        end
        ST_SWAP: begin
          active_d = tgt;
          state_d  = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (leave_full) begin
            state_d = ST_FADE_OUT;
          end else if (gain_q >= GAIN_FULL - GW'(1)) begin
            gain_d  = GAIN_FULL;
            state_d = ST_RUN;
          end else begin
            gain_d = gain_q + GW'(1);
          end
        end
`ifdef FXSEL_MUTE_EN
        ST_MUTED: begin
          gain_d = '0;
          if (!mute_req) state_d = (tgt != active_q) ? ST_SWAP : ST_FADE_IN;
        end
`endif
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Gain multiply uses the pre-update core index and gain
  assign prod_l = PW'(fx_l_arr[active_q]) * PW'($signed({1'b0, gain_q}));
  assign prod_r = PW'(fx_r_arr[active_q]) * PW'($signed({1'b0, gain_q}));

  // Output sample capture: arithmetic shift by taking the bit window
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (bus.VALID) begin
      left_d  = prod_l[RAMP_LOG2 +: 16];
      right_d = prod_r[RAMP_LOG2 +: 16];
    end
  end

  assign unused_bits = ^{req_full[11:0],
                         prod_l[RAMP_LOG2-1:0], prod_l[PW-1:RAMP_LOG2+16],
                         prod_r[RAMP_LOG2-1:0], prod_r[PW-1:RAMP_LOG2+16]};

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      gain_q   <= GAIN_FULL;
      active_q <= '0;
      cand_q   <= '0;
      count_q  <= '0;
      tgt_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      active_q <= active_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      tgt_q    <= tgt;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  // Outputs: busy decoded from state, samples and index from registers
  always_comb begin
    bus.busy = (state_q != ST_RUN);
  end

  assign bus.left_out  = left_q;
  assign bus.right_out = right_q;
  assign bus.active_fx = active_q;

endmodule
